ff_share_arbiter: RTL and testbench
===================================

Name: ff_share_arbiter

Overview:
- Shares one float-to-fixed conversion unit (32-bit float in, 32-bit fixed out, Begin/ACK handshake, FSM reset input) between N_REQ requesters.
- Arbitration is round-robin.
- Sequences the unit: latch operand, assert Begin, wait for ACK, capture result, pulse FSM reset.
- Returns the result to the granted requester and flags conversions that time out.
- Sits between the requesting datapaths and the single conversion coprocessor instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 32, operand/result width.
- TIMEOUT, 64, max WAIT cycles before abort (≥4).

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- REQ  in  N_REQ  per-requester request level; held until GNT
- FLOAT_IN  in  N_REQ*DATA_W  operands; requester i occupies bits [i*DATA_W +: DATA_W]
- GNT  out  N_REQ  one-hot, 1-cycle pulse: operand of that requester latched
- DONE  out  N_REQ  one-hot, 1-cycle pulse: RESULT_OUT valid for that requester
- RESULT_OUT  out  DATA_W  captured result; holds until next DONE
- ERR  out  1  1-cycle pulse coincident with DONE on timeout abort
- BUSY  out  1  high in every state except IDLE
- F  out  DATA_W  operand driven to the conversion unit
- BEGIN_FSM_FF  out  1  start to the conversion unit
- RST_FSM_FF  out  1  FSM reset to the conversion unit
- ACK_FF  in  1  conversion done from the unit
- RESULT_IN  in  DATA_W  fixed-point result from the unit

Behaviour:
- All outputs are registered.
- Reset (RST=1 at a CLK edge):
  - state=IDLE; rr_ptr=0; timeout counter=0.
  - GNT, DONE, ERR, BUSY, BEGIN_FSM_FF = 0; F = 0; RESULT_OUT = 0.
  - RST_FSM_FF = 1 while RST is high, so the conversion unit is cleared alongside this block.
  - Reset mid-conversion abandons the operation: no DONE is issued and the requester must re-request.
- States: IDLE, START, WAIT, CLEAR.
- IDLE:
  - If REQ != 0, select the first asserted REQ at or after rr_ptr, wrapping modulo N_REQ.
  - Next cycle: GNT[idx]=1 for one cycle, F=FLOAT_IN[idx], idx stored, state=START.
  - If REQ == 0, stay in IDLE.
- START (1 cycle): BEGIN_FSM_FF=1, counter cleared, state=WAIT.
- WAIT:
  - BEGIN_FSM_FF stays 1 and F stays stable. The counter increments each cycle.
  - ACK_FF=1: next cycle RESULT_OUT=RESULT_IN, DONE[idx]=1, BEGIN_FSM_FF=0, state=CLEAR.
  - Counter == TIMEOUT-1 with no ACK: next cycle RESULT_OUT=0, DONE[idx]=1, ERR=1, BEGIN_FSM_FF=0, state=CLEAR.
  - ACK_FF and timeout in the same cycle: ACK wins (result captured, ERR=0).
- CLEAR (1 cycle): RST_FSM_FF=1, rr_ptr=(idx+1) mod N_REQ, state=IDLE.
- Latency:
  - REQ seen in IDLE at edge 0 → GNT at edge 1 → BEGIN at edge 2.
  - DONE comes 1 cycle after the first ACK_FF sample.
  - Minimum REQ-to-DONE is 4 cycles. Back-to-back grant spacing is at least 5 cycles.
- Requesters:
  - Drop REQ in the cycle after GNT. A REQ still high is treated as a new request and competes in round-robin order.
  - FLOAT_IN[idx] is only sampled on the IDLE→START edge; later changes are ignored.
- ACK_FF outside WAIT is ignored. REQ changes outside IDLE are ignored (no queuing).
- No requester can be granted twice while another asserted requester is waiting (round-robin fairness).

Decomposition:
- Package ff_arb_pkg holds:
  - state encoding constants (IDLE=2'd0, START=2'd1, WAIT=2'd2, CLEAR=2'd3);
  - default TIMEOUT;
  - DATA_W.
- One sub-module, rr_pick: combinational round-robin priority select. Inputs REQ, rr_ptr; outputs idx and valid. Reusable by other shared coprocessors.
- The top level holds the FSM, operand/result registers and the timeout counter.

Test Plan:
- Bench stub: converter model returning ACK_FF after K cycles with RESULT_IN = F ^ 32'hFFFF_0000; ACK held until RST_FSM_FF.
- Single request: REQ=4'b0010, FLOAT_IN[1]=32'h4049_0FDB, K=3 → GNT=4'b0010 at edge 1, BEGIN at edge 2, DONE=4'b0010 with RESULT_OUT=32'hBFB6_0FDB, ERR=0, RST_FSM_FF pulse 1 cycle later.
- Contention: REQ=4'b1111 held continuously, K=1 → DONE order 0,1,2,3,0; each DONE carries that requester's operand XOR pattern.
- Timeout: stub never ACKs, TIMEOUT=64 → DONE and ERR together exactly 64 cycles after BEGIN rises, RESULT_OUT=0, then CLEAR and IDLE.
- ACK/timeout collision: ACK_FF arrives on the cycle the counter reaches TIMEOUT-1 → ERR=0, result captured.
- Reset mid-WAIT: RST=1 for 1 cycle during WAIT → all outputs at reset values the next cycle, RST_FSM_FF=1 during reset, no DONE, rr_ptr=0.

Source files
------------

// File: rtl/ff_arb_pkg.sv
// ---------------------------------------------------------------------------
// ff_arb_pkg
// Shared definitions for the float-to-fixed coprocessor arbiter:
//   - arb_state_t : sequencer state encoding (IDLE, START, WAIT, CLEAR)
//   - FF_DATA_W   : default operand/result width
//   - FF_TIMEOUT  : default number of WAIT cycles before a conversion is aborted
//   - FF_N_REQ    : default number of requesters
// ---------------------------------------------------------------------------
package ff_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      CLEAR = 2'd3
   } arb_state_t;

   localparam int FF_DATA_W  = 32;
   localparam int FF_TIMEOUT = 64;
   localparam int FF_N_REQ   = 4;

endpackage

// File: rtl/ff_share_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority select. Returns the first asserted
// request at or after the pointer, wrapping modulo N_REQ.
// Ports:
//   i_req    in  N_REQ  request vector
//   i_rr_ptr in  IDX_W  highest-priority position this round (0..N_REQ-1)
//   o_idx    out IDX_W  selected requester (0 when none)
//   o_valid  out 1      at least one request asserted
// ---------------------------------------------------------------------------
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_rr_ptr,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_valid
);

   int w_pos;

   // NOTE: every output of a combinational block gets a default before any
   // branch; a path that leaves a variable unassigned infers a latch.
   always_comb begin
      o_idx   = '0;
      o_valid = 1'b0;
      w_pos   = 0;
      for (int i = 0; i < N_REQ; i++) begin
         // Walk positions ptr, ptr+1, ... with wrap; the first hit wins.
         w_pos = int'(i_rr_ptr) + i;
         if (w_pos >= N_REQ) begin
            w_pos = w_pos - N_REQ;
         end
         if (!o_valid && i_req[w_pos[IDX_W-1:0]]) begin
            o_valid = 1'b1;
            o_idx   = w_pos[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/ff_share_arbiter.sv
// ---------------------------------------------------------------------------
// ff_share_arbiter
// Shares one float-to-fixed conversion unit between N_REQ requesters with
// round-robin arbitration. Sequence per request: latch operand (GNT), drive
// BEGIN until ACK or timeout, return result (DONE, ERR on timeout), then pulse
// the unit's FSM reset. Every output is registered.
// Ports:
//   CLK, RST       clock, synchronous active-high reset
//   REQ            per-requester request level, held until GNT
//   FLOAT_IN       packed operands, requester i at [i*DATA_W +: DATA_W]
//   GNT            one-hot pulse: that requester's operand was latched
//   DONE           one-hot pulse: RESULT_OUT valid for that requester
//   RESULT_OUT     captured result, held until the next DONE
//   ERR            pulse with DONE when the conversion timed out
//   BUSY           high whenever the sequencer is not IDLE
//   F              operand to the conversion unit
//   BEGIN_FSM_FF   start to the conversion unit
//   RST_FSM_FF     FSM reset to the conversion unit
//   ACK_FF         conversion-done from the unit
//   RESULT_IN      fixed-point result from the unit
// ---------------------------------------------------------------------------
module ff_share_arbiter
   import ff_arb_pkg::*;
#(
   parameter int N_REQ   = FF_N_REQ,
   parameter int DATA_W  = FF_DATA_W,
   parameter int TIMEOUT = FF_TIMEOUT
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [N_REQ-1:0]          REQ,
   input  logic [N_REQ*DATA_W-1:0]   FLOAT_IN,
   output logic [N_REQ-1:0]          GNT,
   output logic [N_REQ-1:0]          DONE,
   output logic [DATA_W-1:0]         RESULT_OUT,
   output logic                      ERR,
   output logic                      BUSY,
   output logic [DATA_W-1:0]         F,
   output logic                      BEGIN_FSM_FF,
   output logic                      RST_FSM_FF,
   input  logic                      ACK_FF,
   input  logic [DATA_W-1:0]         RESULT_IN
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(TIMEOUT);

   arb_state_t        r_state, w_state_nxt;
   logic [IDX_W-1:0]  r_ptr, w_ptr_nxt;
   logic [IDX_W-1:0]  r_idx, w_idx_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic [N_REQ-1:0]  r_gnt, w_gnt_nxt;
   logic [N_REQ-1:0]  r_done, w_done_nxt;
   logic              r_err, w_err_nxt;
   logic              r_busy, w_busy_nxt;
   logic              r_begin, w_begin_nxt;
   logic              r_rst_fsm, w_rst_fsm_nxt;
   logic [DATA_W-1:0] r_f, w_f_nxt;
   logic [DATA_W-1:0] r_result, w_result_nxt;

   logic [IDX_W-1:0]  w_pick_idx;
   logic              w_pick_valid;
   logic [DATA_W-1:0] w_ops [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign w_ops[g] = FLOAT_IN[g*DATA_W +: DATA_W];
   end

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .i_req    (REQ),
      .i_rr_ptr (r_ptr),
      .o_idx    (w_pick_idx),
      .o_valid  (w_pick_valid)
   );

   // Each state's visible action is registered on the edge that leaves it:
   // GNT on leaving IDLE, BEGIN on leaving START, DONE on leaving WAIT and
   // the unit's FSM reset on leaving CLEAR.
   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_nxt     = r_ptr;
      w_idx_nxt     = r_idx;
      w_cnt_nxt     = r_cnt;
      w_gnt_nxt     = '0;
      w_done_nxt    = '0;
      w_err_nxt     = 1'b0;
      w_begin_nxt   = r_begin;
      w_rst_fsm_nxt = 1'b0;
      w_f_nxt       = r_f;
      w_result_nxt  = r_result;

      case (r_state)
         IDLE: begin
            if (w_pick_valid) begin
               w_gnt_nxt[w_pick_idx] = 1'b1;
               w_f_nxt               = w_ops[w_pick_idx];
               w_idx_nxt             = w_pick_idx;
               w_state_nxt           = START;
            end
         end
         START: begin
            w_begin_nxt = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = WAIT;
         end
         WAIT: begin
            // ACK is tested first so it wins over a simultaneous timeout.
            if (ACK_FF) begin
               w_result_nxt        = RESULT_IN;
               w_done_nxt[r_idx]   = 1'b1;
               w_begin_nxt         = 1'b0;
               w_state_nxt         = CLEAR;
            end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
               w_result_nxt        = '0;
               w_done_nxt[r_idx]   = 1'b1;
               w_err_nxt           = 1'b1;
               w_begin_nxt         = 1'b0;
               w_state_nxt         = CLEAR;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         CLEAR: begin
            w_rst_fsm_nxt = 1'b1;
            w_ptr_nxt     = (r_idx == IDX_W'(N_REQ - 1)) ? '0 : r_idx + 1'b1;
            w_state_nxt   = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      w_busy_nxt = (w_state_nxt != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= IDLE;
         r_ptr     <= '0;
         r_idx     <= '0;
         r_cnt     <= '0;
         r_gnt     <= '0;
         r_done    <= '0;
         r_err     <= 1'b0;
         r_busy    <= 1'b0;
         r_begin   <= 1'b0;
         r_f       <= '0;
         r_result  <= '0;
         // Hold the conversion unit in reset alongside this block.
         r_rst_fsm <= 1'b1;
      end else begin
         r_state   <= w_state_nxt;
         r_ptr     <= w_ptr_nxt;
         r_idx     <= w_idx_nxt;
         r_cnt     <= w_cnt_nxt;
         r_gnt     <= w_gnt_nxt;
         r_done    <= w_done_nxt;
         r_err     <= w_err_nxt;
         r_busy    <= w_busy_nxt;
         r_begin   <= w_begin_nxt;
         r_f       <= w_f_nxt;
         r_result  <= w_result_nxt;
         r_rst_fsm <= w_rst_fsm_nxt;
      end
   end

   assign GNT          = r_gnt;
   assign DONE         = r_done;
   assign RESULT_OUT   = r_result;
   assign ERR          = r_err;
   assign BUSY         = r_busy;
   assign F            = r_f;
   assign BEGIN_FSM_FF = r_begin;
   assign RST_FSM_FF   = r_rst_fsm;

endmodule

// File: tb/tb_ff_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ff_share_arbiter
// Self-checking bench for ff_share_arbiter. A converter stub raises ACK_FF a
// programmable number of cycles after BEGIN_FSM_FF (0 = never) and returns
// F ^ 32'hFFFF_0000, holding ACK until RST_FSM_FF. Transactions come from a
// table; contention and reset-during-WAIT are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_ff_share_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;

   logic            CLK;
   logic            RST;
   logic [N-1:0]    REQ;
   logic [N*DW-1:0] FLOAT_IN;
   logic [N-1:0]    GNT;
   logic [N-1:0]    DONE;
   logic [DW-1:0]   RESULT_OUT;
   logic            ERR;
   logic            BUSY;
   logic [DW-1:0]   F;
   logic            BEGIN_FSM_FF;
   logic            RST_FSM_FF;
   logic            ACK_FF;
   logic [DW-1:0]   RESULT_IN;

   int n_vec    = 0;
   int n_miss   = 0;
   int cyc      = 0;
   int ack_k    = 0;
   int stub_cnt = 0;

   logic [DW-1:0] ops [N];

   typedef struct {
      logic [N-1:0]  req;
      int            k;
      bit            hold;
      int            idx;
      int            lat;
      logic [DW-1:0] res;
      bit            err;
   } txn_t;

   txn_t tbl [6];

   ff_share_arbiter dut (
      .CLK          (CLK),
      .RST          (RST),
      .REQ          (REQ),
      .FLOAT_IN     (FLOAT_IN),
      .GNT          (GNT),
      .DONE         (DONE),
      .RESULT_OUT   (RESULT_OUT),
      .ERR          (ERR),
      .BUSY         (BUSY),
      .F            (F),
      .BEGIN_FSM_FF (BEGIN_FSM_FF),
      .RST_FSM_FF   (RST_FSM_FF),
      .ACK_FF       (ACK_FF),
      .RESULT_IN    (RESULT_IN)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Converter stub.
   always @(posedge CLK) begin
      if (RST || RST_FSM_FF) begin
         ACK_FF   <= 1'b0;
         stub_cnt <= 0;
      end else if (BEGIN_FSM_FF && !ACK_FF && ack_k != 0) begin
         if (stub_cnt == ack_k - 1) ACK_FF <= 1'b1;
         stub_cnt <= stub_cnt + 1;
      end
   end
   assign RESULT_IN = F ^ 32'hFFFF_0000;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_gnt"},    32'(GNT), 32'd0);
      check({tag, "_done"},   32'(DONE), 32'd0);
      check({tag, "_err"},    32'(ERR), 32'd0);
      check({tag, "_busy"},   32'(BUSY), 32'd0);
      check({tag, "_begin"},  32'(BEGIN_FSM_FF), 32'd0);
      check({tag, "_f"},      F, 32'd0);
      check({tag, "_result"}, RESULT_OUT, 32'd0);
      check({tag, "_rstfsm"}, 32'(RST_FSM_FF), 32'd1);
   endtask

   // One full request: grant, begin, done/err with latency from BEGIN rise,
   // then the one-cycle FSM-reset pulse back in IDLE.
   task automatic run_txn(input int id, input logic [N-1:0] req, input int k, input bit hold,
                          input int exp_idx, input int exp_lat, input logic [DW-1:0] exp_res,
                          input bit exp_err);
      logic [N-1:0] exp_oh;
      bit           seen;
      int           t_begin;
      exp_oh = N'(1) << exp_idx;
      ack_k  = k;
      REQ    = req;
      seen   = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge CLK);
         seen = (GNT != '0);
      end
      check($sformatf("t%0d_gnt_seen", id), 32'(seen), 32'd1);
      check($sformatf("t%0d_gnt", id), 32'(GNT), 32'(exp_oh));
      check($sformatf("t%0d_f", id), F, ops[exp_idx]);
      check($sformatf("t%0d_busy", id), 32'(BUSY), 32'd1);
      if (!hold) REQ = '0;
      @(negedge CLK);
      check($sformatf("t%0d_begin", id), 32'(BEGIN_FSM_FF), 32'd1);
      t_begin = cyc;
      seen    = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         @(negedge CLK);
         seen = (DONE != '0);
      end
      check($sformatf("t%0d_done_seen", id), 32'(seen), 32'd1);
      check($sformatf("t%0d_done", id), 32'(DONE), 32'(exp_oh));
      check($sformatf("t%0d_result", id), RESULT_OUT, exp_res);
      check($sformatf("t%0d_err", id), 32'(ERR), 32'(exp_err));
      check($sformatf("t%0d_latency", id), 32'(cyc - t_begin), 32'(exp_lat));
      check($sformatf("t%0d_begin_low", id), 32'(BEGIN_FSM_FF), 32'd0);
      @(negedge CLK);
      check($sformatf("t%0d_rstfsm", id), 32'(RST_FSM_FF), 32'd1);
      check($sformatf("t%0d_done_pulse", id), 32'(DONE), 32'd0);
      check($sformatf("t%0d_err_pulse", id), 32'(ERR), 32'd0);
      check($sformatf("t%0d_idle", id), 32'(BUSY), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      int n_done;

      ops[0] = 32'h3F80_0000;
      ops[1] = 32'h4049_0FDB;
      ops[2] = 32'hC120_0000;
      ops[3] = 32'h0000_0001;
      FLOAT_IN = {ops[3], ops[2], ops[1], ops[0]};

      // Pointer after each row: 2, 1, 0, 3, 1, 1.
      tbl[0] = '{req: 4'b0010, k: 3,  hold: 1'b0, idx: 1, lat: 4,  res: 32'hBFB6_0FDB, err: 1'b0};
      tbl[1] = '{req: 4'b0011, k: 1,  hold: 1'b0, idx: 0, lat: 2,  res: 32'hC07F_0000, err: 1'b0};
      tbl[2] = '{req: 4'b1001, k: 2,  hold: 1'b0, idx: 3, lat: 3,  res: 32'hFFFF_0001, err: 1'b0};
      tbl[3] = '{req: 4'b1100, k: 0,  hold: 1'b0, idx: 2, lat: 64, res: 32'h0000_0000, err: 1'b1};
      tbl[4] = '{req: 4'b0101, k: 63, hold: 1'b0, idx: 0, lat: 64, res: 32'hC07F_0000, err: 1'b0};
      tbl[5] = '{req: 4'b0001, k: 62, hold: 1'b0, idx: 0, lat: 63, res: 32'hC07F_0000, err: 1'b0};

      RST = 1'b1;
      REQ = '0;
      repeat (3) @(negedge CLK);
      check_reset_outputs("por");
      RST = 1'b0;
      @(negedge CLK);
      check("por_rstfsm_release", 32'(RST_FSM_FF), 32'd0);

      for (int i = 0; i < 6; i++) begin
         run_txn(i, tbl[i].req, tbl[i].k, tbl[i].hold, tbl[i].idx, tbl[i].lat, tbl[i].res, tbl[i].err);
      end

      // Contention from a fresh reset: all four held, grants rotate 0,1,2,3,0.
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      run_txn(10, 4'b1111, 1, 1'b1, 0, 2, 32'hC07F_0000, 1'b0);
      run_txn(11, 4'b1111, 1, 1'b1, 1, 2, 32'hBFB6_0FDB, 1'b0);
      run_txn(12, 4'b1111, 1, 1'b1, 2, 2, 32'h3EDF_0000, 1'b0);
      run_txn(13, 4'b1111, 1, 1'b1, 3, 2, 32'hFFFF_0001, 1'b0);
      run_txn(14, 4'b1111, 1, 1'b0, 0, 2, 32'hC07F_0000, 1'b0);

      // Reset in the middle of WAIT: requester 3 is abandoned.
      ack_k = 0;
      REQ   = 4'b1000;
      seen  = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge CLK);
         seen = (GNT != '0);
      end
      check("mid_gnt_seen", 32'(seen), 32'd1);
      check("mid_gnt", 32'(GNT), 32'b1000);
      REQ = '0;
      repeat (5) @(negedge CLK);
      check("mid_begin", 32'(BEGIN_FSM_FF), 32'd1);
      check("mid_busy", 32'(BUSY), 32'd1);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      check_reset_outputs("mid");
      n_done = 0;
      for (int c = 0; c < 80; c++) begin
         @(negedge CLK);
         if (DONE != '0) n_done++;
      end
      check("mid_no_done", 32'(n_done), 32'd0);
      check("mid_idle", 32'(BUSY), 32'd0);
      // Pointer was 1 before the reset; after it requester 0 must win.
      run_txn(20, 4'b1111, 1, 1'b0, 0, 2, 32'hC07F_0000, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
